// File: rtl/bus_grant_arbiter.sv
`default_nettype none
// bus_grant_arbiter: 32-source round-robin arbiter with a registered zero/one-hot grant.
// Optional hold limit (MAX_HOLD cycles per tenure) compiled in with ARB_HOLD_LIMIT_EN. Rev 1.0
module bus_grant_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        enable,
  input  logic [31:0] req,
  output logic [31:0] grant,
  output logic        grant_valid,
  output logic [4:0]  owner,
  output logic        owner_change
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OWNED = 1'b1;

  if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_max_hold_check
    $error("bus_grant_arbiter: MAX_HOLD must be in 2..255");
  end

  logic [0:0]  state, state_n;
  logic [4:0]  ptr, ptr_n;
  logic [31:0] grant_n;
  logic [4:0]  owner_n;
  logic        change_n;

  logic        owner_req;
  logic        others;
  logic        expiry;
  logic [31:0] cand;
  logic        win_found;
  logic [4:0]  win_idx;
  logic [4:0]  idx;
  logic        take;

  assign owner_req = |(req & grant);
  assign others    = |(req & ~grant);

`ifdef ARB_HOLD_LIMIT_EN
  logic [7:0] hold_cnt, hold_n;
  assign expiry = owner_req && (hold_cnt == 8'(MAX_HOLD - 1));
`else
  assign expiry = 1'b0;
`endif

  // On hold expiry the current owner sits out this search so another source wins.
  assign cand = expiry ? (req & ~grant) : req;

  // Scan from ptr+1 upward with wrap; descending loop leaves the nearest hit.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int i = 31; i >= 0; i--) begin
      idx = ptr + 5'(i) + 5'd1;
      if (cand[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    state_n  = state;
    grant_n  = grant;
    owner_n  = owner;
    ptr_n    = ptr;
    change_n = 1'b0;
    take     = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    hold_n   = hold_cnt;
`endif
    if (state == IDLE) begin
      take = enable && win_found;
    end else if (!enable || (!owner_req && !win_found)) begin
      state_n = IDLE;
      grant_n = '0;
    end else if (!owner_req || (expiry && others)) begin
      take = 1'b1;
    end else begin
`ifdef ARB_HOLD_LIMIT_EN
      hold_n = expiry ? 8'd0 : hold_cnt + 8'd1;
`endif
    end

    if (take) begin
      state_n  = OWNED;
      grant_n  = 32'd1 << win_idx;
      owner_n  = win_idx;
      ptr_n    = win_idx;
      change_n = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
      hold_n   = 8'd0;
`endif
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state        <= IDLE;
      grant        <= '0;
      owner        <= '0;
      ptr          <= 5'd31;
      owner_change <= 1'b0;
    end else begin
      state        <= state_n;
      grant        <= grant_n;
      owner        <= owner_n;
      ptr          <= ptr_n;
      owner_change <= change_n;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hold_cnt <= 8'd0;
    end else begin
      hold_cnt <= hold_n;
    end
  end
`endif

  assign grant_valid = (state == OWNED);

endmodule
`default_nettype wire
